// File: rtl/instruction_prefetcher_pkg.sv
// instruction_prefetcher_pkg: fetch-stage widths, FIFO depth and counter sizing shared by the prefetcher.
package instruction_prefetcher_pkg;
    localparam int IMEM_ADDR_WIDTH = 16;
    localparam int IMEM_DATA_WIDTH = 16;
    localparam int PREFETCH_DEPTH  = 4;
    function automatic int cnt_width(int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/instruction_prefetcher_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush and occupancy count; dout shows the head entry.
module sync_fifo import instruction_prefetcher_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instruction_prefetcher.sv
// instruction_prefetcher: sequential instruction fetch with credit-limited requests, a small
// instruction FIFO toward decode, and redirect that flushes buffered and in-flight fetches.
module instruction_prefetcher import instruction_prefetcher_pkg::*; #(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int DEPTH = PREFETCH_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  protocol_error
);
    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 1;
    logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, head_pc;
    logic [DATA_WIDTH-1:0] head_instr;
    logic [CW-1:0] outstanding, discard, count;
    logic issue, rv_ok, push, pop;
    // Buffered plus in-flight never exceeds DEPTH, so a response always finds room.
    assign imem_req    = !reset && !redirect_valid && SW'(count) + SW'(outstanding) < SW'(DEPTH);
    assign imem_addr   = fetch_pc;
    assign issue       = imem_req && imem_gnt;
    assign rv_ok       = imem_rvalid && outstanding != '0;
    assign push        = rv_ok && discard == '0 && !redirect_valid;
    assign instr_valid = !reset && count != '0;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = instr_valid ? head_instr : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;
    sync_fifo #(.WIDTH(DATA_WIDTH + ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din({imem_rdata, resp_pc}),
        .dout({head_instr, head_pc}),
        .count(count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            resp_pc        <= RESET_PC;
            outstanding    <= '0;
            discard        <= '0;
            protocol_error <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rv_ok);
            if (imem_rvalid && outstanding == '0) protocol_error <= 1'b1;
            // Everything still in flight after a redirect belongs to the old path.
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding - CW'(rv_ok);
            end else begin
                if (issue) fetch_pc <= fetch_pc + 1'b1;
                if (push) resp_pc <= resp_pc + 1'b1;
                if (rv_ok && discard != '0) discard <= discard - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_prefetcher.sv
// tb_instruction_prefetcher: table vectors, directed redirect corners and a randomized
// scoreboard run against a simple in-order memory model.
module tb_instruction_prefetcher;
    logic clock = 1'b0, reset = 1'b1;
    logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect_valid = 1'b0;
    logic instr_valid, instr_ready = 1'b0, protocol_error;
    logic [7:0] imem_addr, redirect_pc = '0, instr_pc;
    logic [15:0] imem_rdata = '0, instr;
    logic w_req, w_rvalid = 1'b0, w_valid, w_perr;
    logic [7:0] w_addr, w_pc, w_a = '0;
    logic [15:0] w_rdata = '0, w_instr;
    bit inject = 1'b0, w_iss = 1'b0;
    int n_cmp = 0, n_bad = 0, cyc = 0, mem_lat = 1, gnt_mode = 1;
    typedef struct {logic [7:0] a; int due;} pend_t;
    typedef struct {bit ready; bit req; bit valid; logic [7:0] pc; logic [7:0] wpc;} vec_t;
    pend_t pend[$];

    always #5 clock = ~clock;

    instruction_prefetcher #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .protocol_error(protocol_error)
    );

    instruction_prefetcher #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4), .RESET_PC(8'hFE)) dut_w (
        .clock(clock), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(8'h00), .instr_valid(w_valid),
        .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_pc), .protocol_error(w_perr)
    );

    function automatic logic [15:0] mw(logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_perr", protocol_error, 0);
        tick();
        reset = 1'b0;
    endtask

    // Memory: in-order, fixed latency, data = 16'h1000 + address; reset along with the DUT.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
                w_iss = 1'b0;
            end else begin
                if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + mem_lat});
                w_iss = w_req;
                w_a = w_addr;
            end
            @(posedge clock);
            #1;
            cyc++;
            imem_gnt = gnt_mode == 2 ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
            imem_rvalid = 1'b0;
            imem_rdata = 16'($urandom);
            if (inject) begin
                imem_rvalid = 1'b1;
                inject = 1'b0;
            end else if (pend.size() != 0 && pend[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata = mw(pend[0].a);
                void'(pend.pop_front());
            end
            w_rvalid = w_iss;
            w_rdata = mw(w_a);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        int k, pops;
        bit got;
        logic [7:0] exp_pc;
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00},
            '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00},
            '{1'b1, 1'b1, 1'b1, 8'h00, 8'hFE},
            '{1'b1, 1'b1, 1'b1, 8'h01, 8'hFF},
            '{1'b1, 1'b1, 1'b1, 8'h02, 8'h00},
            '{1'b1, 1'b1, 1'b1, 8'h03, 8'h01},
            '{1'b0, 1'b1, 1'b1, 8'h04, 8'h02},
            '{1'b0, 1'b1, 1'b1, 8'h04, 8'h03},
            '{1'b0, 1'b0, 1'b1, 8'h04, 8'h04},
            '{1'b1, 1'b0, 1'b1, 8'h04, 8'h05},
            '{1'b1, 1'b1, 1'b1, 8'h05, 8'h06}
        };
        mem_lat = 1;
        gnt_mode = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            instr_ready = tbl[i].ready;
            @(negedge clock);
            check("t1_req", imem_req, tbl[i].req);
            check("t1_valid", instr_valid, tbl[i].valid);
            check("t1_pc", instr_pc, tbl[i].valid ? tbl[i].pc : 8'h00);
            check("t1_instr", instr, tbl[i].valid ? mw(tbl[i].pc) : 16'h0000);
            check("t3_valid", w_valid, tbl[i].valid);
            check("t3_pc", w_pc, tbl[i].valid ? tbl[i].wpc : 8'h00);
            check("t3_instr", w_instr, tbl[i].valid ? mw(tbl[i].wpc) : 16'h0000);
            tick();
        end

        do_reset();
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (imem_req && imem_gnt) k++;
            tick();
        end
        @(negedge clock);
        check("t2_issued", k, 4);
        check("t2_req_stalled", imem_req, 0);
        check("t2_valid_held", instr_valid, 1);
        tick();
        instr_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            @(negedge clock);
            if (instr_valid) begin
                check("t2_pc", instr_pc, k);
                check("t2_instr", instr, mw(8'(k)));
                k++;
            end
            tick();
        end
        check("t2_drained", k, 4);

        mem_lat = 3;
        do_reset();
        @(negedge clock);
        tick();
        @(negedge clock);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clock);
        check("t4_req_in_redirect", imem_req, 0);
        check("t4_in_flight", pend.size(), 2);
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (instr_valid) begin
                got = 1'b1;
                check("t4_pc", instr_pc, 8'h40);
                check("t4_instr", instr, mw(8'h40));
            end
            tick();
        end
        check("t4_arrived", got, 1);

        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h20;
        @(negedge clock);
        check("t5_pop_pending", instr_valid, 1);
        check("t5_rvalid_pending", imem_rvalid, 1);
        check("t5_req_in_redirect", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t5_flushed_a", instr_valid, 0);
        tick();
        @(negedge clock);
        check("t5_flushed_b", instr_valid, 0);
        tick();
        @(negedge clock);
        check("t5_valid", instr_valid, 1);
        check("t5_pc", instr_pc, 8'h20);
        check("t5_instr", instr, mw(8'h20));
        tick();

        mem_lat = 2;
        gnt_mode = 2;
        do_reset();
        exp_pc = 8'h00;
        pops = 0;
        for (int c = 0; c < 20000 && pops < 1000; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            redirect_valid = $urandom_range(0, 31) == 0;
            redirect_pc = 8'($urandom);
            @(negedge clock);
            if (redirect_valid) begin
                check("t6_req_in_redirect", imem_req, 0);
                exp_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                check("t6_pc", instr_pc, exp_pc);
                check("t6_instr", instr, mw(exp_pc));
                exp_pc++;
                pops++;
            end
            if (!instr_valid) check("t6_idle_zero", {instr, instr_pc}, 0);
            check("t6_in_flight_bound", pend.size() <= 4, 1);
            tick();
        end
        redirect_valid = 1'b0;
        check("t6_progress", pops >= 1000, 1);
        check("t6_no_perr", protocol_error, 0);

        gnt_mode = 0;
        do_reset();
        @(negedge clock);
        check("t6_perr_clear", protocol_error, 0);
        inject = 1'b1;
        tick();
        @(negedge clock);
        tick();
        gnt_mode = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t6_perr_sticky", protocol_error, 1);
            tick();
        end
        do_reset();
        check("t3_no_perr", w_perr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
